// File: rtl/input_port_buffer.sv
// Per-input-port flit buffer: one FIFO per virtual channel, head flit exposed to each VC controller.
// Optional packet-framing checker enabled by defining INPUT_BUFFER_PKT_CHECK_EN.
//
// Packet-check state machine, one per VC (write side):
//   state  | meaning
//   IDLE   | between packets; expects HEAD or a single-flit packet
//   IN_PKT | HEAD accepted; expects BODY or TAIL

`ifndef HEAD
`define HEAD 2'b01
`endif
`ifndef BODY
`define BODY 2'b10
`endif
`ifndef TAIL
`define TAIL 2'b11
`endif

module input_port_buffer #(
  parameter int DW    = 32,
  parameter int V     = 4,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  input  logic [V-1:0]    in_vc,
  input  logic [DW-1:0]   in_data,
  output logic [V*DW-1:0] out_data,
  output logic [V-1:0]    out_valid,
  input  logic [V-1:0]    pop,
  output logic [V-1:0]    credit_out,
  output logic [V-1:0]    err_overflow,
  output logic            err_vc
`ifdef INPUT_BUFFER_PKT_CHECK_EN
  ,
  output logic [V-1:0]    err_pkt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic vc_onehot;
  logic vc_bad;

  assign vc_onehot = $onehot(in_vc);
  assign vc_bad    = in_valid & ~vc_onehot;

`ifdef INPUT_BUFFER_PKT_CHECK_EN
  typedef enum logic {IDLE, IN_PKT} pkt_state_t;

  logic [1:0] ftype;
  assign ftype = in_data[DW-3:DW-4];
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_vc <= 1'b0;
    end else if (vc_bad) begin
      err_vc <= 1'b1;
    end
  end

  for (genvar i = 0; i < V; i++) begin : g_vc
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [DW-1:0] mem [DEPTH];
    logic          empty;
    logic          full;
    logic          rd;
    logic          req;
    logic          wr;
    logic          credit_q;
    logic          ovf_q;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
    assign rd    = pop[i] & ~empty;
    assign req   = in_valid & vc_onehot & in_vc[i];
    // A same-cycle pop frees the slot, so a full FIFO can still accept.
    assign wr    = req & (~full | rd);

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        wptr     <= '0;
        rptr     <= '0;
        credit_q <= 1'b0;
        ovf_q    <= 1'b0;
      end else begin
        if (wr) wptr <= wptr + PW'(1);
        if (rd) rptr <= rptr + PW'(1);
        credit_q <= rd;
        if (req && !wr) ovf_q <= 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (wr) mem[wptr[AW-1:0]] <= in_data;
    end

    assign out_data[i*DW +: DW] = mem[rptr[AW-1:0]];
    assign out_valid[i]         = ~empty;
    assign credit_out[i]        = credit_q;
    assign err_overflow[i]      = ovf_q;

`ifdef INPUT_BUFFER_PKT_CHECK_EN
    pkt_state_t st;
    logic       pkt_err;

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        st      <= IDLE;
        pkt_err <= 1'b0;
      end else if (wr) begin
        case (ftype)
          `HEAD: begin
            if (st == IN_PKT) pkt_err <= 1'b1;
            st <= IN_PKT;
          end
          `BODY: begin
            if (st == IDLE) pkt_err <= 1'b1;
          end
          `TAIL: begin
            if (st == IDLE) pkt_err <= 1'b1;
            st <= IDLE;
          end
          default: begin
            if (st == IN_PKT) pkt_err <= 1'b1;
            st <= IDLE;
          end
        endcase
      end
    end

    assign err_pkt[i] = pkt_err;
`endif
  end

endmodule

// File: tb/tb_input_port_buffer.sv
// Bench for input_port_buffer: directed stimulus, expected flits queued per VC and
// checked by a monitor whenever the DUT hands a head flit to a popping controller.

module tb_input_port_buffer;

  localparam int DW = 32;
  localparam int V  = 4;

  logic            clk = 1'b0;
  logic            rstn;
  logic            in_valid;
  logic [V-1:0]    in_vc;
  logic [DW-1:0]   in_data;
  logic [V*DW-1:0] out_data;
  logic [V-1:0]    out_valid;
  logic [V-1:0]    pop;
  logic [V-1:0]    credit_out;
  logic [V-1:0]    err_overflow;
  logic            err_vc;
`ifdef INPUT_BUFFER_PKT_CHECK_EN
  logic [V-1:0]    err_pkt;
`endif

  input_port_buffer #(.DW(DW), .V(V), .DEPTH(4)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .in_valid     (in_valid),
    .in_vc        (in_vc),
    .in_data      (in_data),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .pop          (pop),
    .credit_out   (credit_out),
    .err_overflow (err_overflow),
    .err_vc       (err_vc)
`ifdef INPUT_BUFFER_PKT_CHECK_EN
    ,
    .err_pkt      (err_pkt)
`endif
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  logic [DW-1:0] exp_q [V][$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  // Monitor: a popped head flit must be the oldest expected flit of that VC.
  always @(negedge clk) begin
    if (rstn) begin
      for (int i = 0; i < V; i++) begin
        if (pop[i] && out_valid[i]) begin
          if (exp_q[i].size() == 0) begin
            chk($sformatf("unexpected_head_vc%0d", i), {32'h0, out_data[i*DW +: DW]}, 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            chk($sformatf("head_vc%0d", i), {32'h0, out_data[i*DW +: DW]}, {32'h0, exp_q[i][0]});
            void'(exp_q[i].pop_front());
          end
        end
      end
    end
  end

  // One clock: apply inputs for the next edge, return 1ns after it with inputs idle.
  task automatic step(input logic v, input logic [V-1:0] vc, input logic [DW-1:0] d,
                      input logic [V-1:0] p);
    in_valid = v;
    in_vc    = vc;
    in_data  = d;
    pop      = p;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_vc    = '0;
    in_data  = '0;
    pop      = '0;
  endtask

  // Issue a write expected to be accepted, optionally with a same-cycle pop.
  task automatic push(input int vc, input logic [DW-1:0] d, input logic [V-1:0] p);
    exp_q[vc].push_back(d);
    step(1'b1, V'(1) << vc, d, p);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < V; i++) exp_q[i].delete();
    rstn = 1'b1;
  endtask

  initial begin
    in_valid = 1'b0;
    in_vc    = '0;
    in_data  = '0;
    pop      = '0;
    rstn     = 1'b1;
    #1;
    do_reset();

    // Idle after reset
    repeat (5) step(1'b0, '0, '0, '0);
    chk("rst_out_valid", {60'h0, out_valid}, 64'h0);
    chk("rst_credit", {60'h0, credit_out}, 64'h0);
    chk("rst_err_overflow", {60'h0, err_overflow}, 64'h0);
    chk("rst_err_vc", {63'h0, err_vc}, 64'h0);

    // Single flit on VC1, one-cycle latency, pop and credit
    push(1, 32'hA000_0001, '0);
    chk("wr1_out_valid", {60'h0, out_valid}, 64'h2);
    chk("wr1_out_data", {32'h0, out_data[63:32]}, 64'hA000_0001);
    step(1'b0, '0, '0, 4'b0010);
    chk("pop1_out_valid", {60'h0, out_valid}, 64'h0);
    chk("pop1_credit", {60'h0, credit_out}, 64'h2);
    step(1'b0, '0, '0, '0);
    chk("pop1_credit_end", {60'h0, credit_out}, 64'h0);

    // Fill VC0, overflow, drain with back-to-back credits
    for (int k = 1; k <= 4; k++) push(0, DW'(k), '0);
    chk("full0_out_valid", {60'h0, out_valid}, 64'h1);
    chk("full0_no_ovf", {60'h0, err_overflow}, 64'h0);
    step(1'b1, 4'b0001, 32'h5, '0);
    chk("ovf0_err", {60'h0, err_overflow}, 64'h1);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, '0, '0, 4'b0001);
      chk($sformatf("drain0_credit_%0d", k), {60'h0, credit_out}, 64'h1);
    end
    chk("drain0_empty", {60'h0, out_valid}, 64'h0);
    step(1'b0, '0, '0, '0);
    chk("drain0_credit_end", {60'h0, credit_out}, 64'h0);

    // VC2 full with same-cycle push+pop, then wrap the pointers
    for (int k = 1; k <= 4; k++) push(2, 32'h20 + DW'(k), '0);
    push(2, 32'h9, 4'b0100);
    chk("full2_pushpop_no_ovf", {60'h0, err_overflow}, 64'h1);
    chk("full2_pushpop_valid", {60'h0, out_valid}, 64'h4);
    chk("full2_pushpop_credit", {60'h0, credit_out}, 64'h4);
    for (int k = 0; k < 8; k++) push(2, 32'h30 + DW'(k), 4'b0100);
    for (int k = 0; k < 4; k++) step(1'b0, '0, '0, 4'b0100);
    chk("drain2_empty", {60'h0, out_valid}, 64'h0);
    chk("drain2_ovf_unchanged", {60'h0, err_overflow}, 64'h1);

    // Bad VC IDs and pop on empty VC3
    chk("pre_err_vc", {63'h0, err_vc}, 64'h0);
    step(1'b1, 4'b0101, 32'hDEAD, '0);
    chk("multihot_err_vc", {63'h0, err_vc}, 64'h1);
    step(1'b1, 4'b0000, 32'hBEEF, '0);
    chk("badvc_no_write", {60'h0, out_valid}, 64'h0);
    step(1'b0, '0, '0, 4'b1000);
    chk("pop_empty_no_credit", {60'h0, credit_out}, 64'h0);
    step(1'b0, '0, '0, '0);
    chk("pop_empty_no_credit2", {60'h0, credit_out}, 64'h0);
    chk("err_vc_sticky", {63'h0, err_vc}, 64'h1);

    chk("queues_drained", 64'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()), 64'h0);

`ifdef INPUT_BUFFER_PKT_CHECK_EN
    do_reset();
    push(0, 32'h1000_0000, '0);
    push(0, 32'h2000_0000, '0);
    push(0, 32'h3000_0000, '0);
    chk("pkt_hbt_ok", {60'h0, err_pkt}, 64'h0);
    push(0, 32'h2000_0001, '0);
    chk("pkt_body_idle", {60'h0, err_pkt}, 64'h1);
    push(1, 32'h1000_0002, '0);
    chk("pkt_head_ok", {60'h0, err_pkt}, 64'h1);
    push(1, 32'h1000_0003, '0);
    chk("pkt_head_head", {60'h0, err_pkt}, 64'h3);
`endif

    // Mid-stream asynchronous reset with flits pending
    push(3, 32'h77, '0);
    step(1'b1, 4'b0011, 32'h1, '0);
    chk("pre_rst_valid_vc3", {63'h0, out_valid[3]}, 64'h1);
    #2;
    rstn = 1'b0;
    #1;
    chk("async_rst_out_valid", {60'h0, out_valid}, 64'h0);
    chk("async_rst_err_vc", {63'h0, err_vc}, 64'h0);
    chk("async_rst_err_ovf", {60'h0, err_overflow}, 64'h0);
    chk("async_rst_credit", {60'h0, credit_out}, 64'h0);
`ifdef INPUT_BUFFER_PKT_CHECK_EN
    chk("async_rst_err_pkt", {60'h0, err_pkt}, 64'h0);
`endif
    for (int i = 0; i < V; i++) exp_q[i].delete();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (2) step(1'b0, '0, '0, '0);
    chk("post_rst_out_valid", {60'h0, out_valid}, 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/input_port_buffer.md
Name: input_port_buffer

Overview:
Per-input-port flit buffer: V independent FIFOs, one per virtual channel, sitting directly upstream of the input VC controllers.
- Demuxes incoming link flits by VC ID into the VC's FIFO.
- Exposes each FIFO's head flit and a not-empty flag to that VC's controller (its data/valid inputs).
- Pops on switch-allocation grant and returns one credit per popped flit to the upstream router.

Parameters:
DW, 32, flit width in bits; flit type field at [DW-3:DW-4], encoded with the global `HEAD/`BODY/`TAIL macros.
V, 4, number of virtual channels per port.
DEPTH, 4, flits per VC FIFO; power of two, >=2.

Ports:
clk  input  1  clock, rising edge
rstn  input  1  asynchronous active-low reset
in_valid  input  1  incoming flit valid on link
in_vc  input  V  one-hot VC ID of incoming flit
in_data  input  DW  incoming flit
out_data  output  V*DW  head flit of VC i at [i*DW +: DW]
out_valid  output  V  bit i = FIFO i not empty
pop  input  V  bit i = VC i granted by switch allocator this cycle
credit_out  output  V  one-cycle credit pulse to upstream, bit per VC
err_overflow  output  V  sticky: write dropped on full FIFO
err_vc  output  1  sticky: in_valid with in_vc not exactly one-hot

Behaviour:
- Reset (rstn low, asynchronous): all pointers 0, out_valid=0, credit_out=0, err_* = 0. out_data is undefined/don't-care while out_valid=0.
- Pointers: read and write pointers are clog2(DEPTH)+1 bits, with the MSB as wrap bit.
  - empty = pointers equal.
  - full = low bits equal and MSBs differ.
  - Pointers wrap naturally modulo 2*DEPTH.
- Write: in_valid & in_vc[i] & in_vc one-hot -> in_data stored at wptr[i], wptr[i]++ on the clock edge.
  - Write latency is 1 cycle: flit written at edge t appears on out_data slice i and raises out_valid[i] after edge t.
  - There is no combinational bypass.
- Read: out_data slice i is combinationally the entry at rptr[i].
  - pop[i] & out_valid[i] -> rptr[i]++.
  - pop[i] while empty is ignored: no pointer change, no credit.
- Simultaneous push and pop on the same VC: both take effect.
  - If the FIFO is full, the pop frees a slot in the same cycle, so the write is accepted and the count is unchanged.
  - If the FIFO is empty, the new flit is not popped: pop is gated by out_valid, which is 0.
- Push to a full FIFO without a same-cycle pop: the flit is dropped and err_overflow[i] is set.
  - This indicates an upstream credit protocol violation.
- in_valid with in_vc zero or multi-hot: no write to any FIFO, err_vc is set.
- Credits: credit_out[i] is registered and pulses high for exactly 1 cycle, the cycle after each accepted pop. Back-to-back pops give back-to-back pulses.
- Independent VCs: pushes and pops on different VCs in the same cycle do not interact.
- Sticky errors clear only on reset.
- Reset mid-packet discards all buffered flits. No credits are issued for discarded flits; upstream is reset concurrently.

Optional Feature:
INPUT_BUFFER_PKT_CHECK_EN
- Defined:
  - Adds output err_pkt[V-1:0] (sticky, reset 0) and a per-VC write-side state machine {IDLE, IN_PKT}, reset IDLE.
  - Transitions on each accepted write:
    - HEAD: IDLE->IN_PKT.
    - BODY: IN_PKT stays.
    - TAIL: IN_PKT->IDLE.
    - Any other type code is a single-flit packet: legal in IDLE, stays IDLE.
  - Illegal cases (HEAD or single in IN_PKT; BODY/TAIL in IDLE) set err_pkt[i].
    - The flit is still written.
    - State after an illegal flit: HEAD or single -> IN_PKT or IDLE respectively; BODY -> unchanged; TAIL -> IDLE.
  - Dropped writes (overflow, bad in_vc) do not advance the state machine.
- Undefined: no err_pkt port and no state machines; buffering behaviour is identical.

Test Plan:
(DW=32, V=4, DEPTH=4)
1. Reset then idle 5 cycles -> out_valid=4'b0000, credit_out=0, err_overflow=0, err_vc=0.
2. Write 0xA0000001 on in_vc=4'b0010 at edge t -> out_valid=4'b0010 and out_data[63:32]=0xA0000001 after t. pop[1] at t+1 -> out_valid[1]=0 after t+1, credit_out=4'b0010 for exactly the cycle after t+1.
3. Write 4 flits 0x1..0x4 to VC0 -> full; 5th write 0x5 with no pop -> dropped, err_overflow=4'b0001. Then pop 4 times -> head sequence 0x1,0x2,0x3,0x4 and 4 credit pulses.
4. VC2 full, same-cycle write 0x9 and pop[2] -> write accepted, no error. The subsequent head sequence ends with 0x9; 8 consecutive push+pop cycles wrap the pointers with data intact.
5. in_valid=1 with in_vc=4'b0101, and separately with in_vc=4'b0000 -> no FIFO changes, err_vc=1. pop[3] on empty VC3 -> no credit_out pulse.
6. With INPUT_BUFFER_PKT_CHECK_EN: on VC0 write HEAD, BODY, TAIL -> err_pkt=0. Then BODY in IDLE -> err_pkt[0]=1. Then HEAD, HEAD on VC1 -> err_pkt[1]=1. Assert rstn low mid-stream -> all err_* and out_valid=0 immediately.
